// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the carry-save sequential multiplier.
//   csa_state_t : 2-bit FSM state encoding (IDLE, RUN, RESOLVE, DONE)
//   cnt_width() : width of the RUN step counter, clog2(WIDTH/K), minimum 1
// -----------------------------------------------------------------------------
package csa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } csa_state_t;

    // When WIDTH/K == 1 the clog2 would be 0; a 1-bit counter keeps the
    // declaration legal and the compare against STEPS-1 still works.
    function automatic int cnt_width(input int width, input int k);
        int steps;
        steps = width / k;
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/csa_seq_mult_if.sv
// -----------------------------------------------------------------------------
// csa_seq_mult_if
// Operand/result handshake bundle for csa_seq_mult.
//   in_valid/in_ready : operand handshake (a_i, b_i, optional acc_i)
//   out_valid/out_ready : result handshake (result_o)
//   busy : high while the multiplier is in RUN or RESOLVE
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid && ready; the producer holds valid and payload stable until
// that edge, the consumer may raise ready at any time.
// Optional macro CSA_SEQ_MULT_ACCUM_EN adds acc_i (accumulate request).
// -----------------------------------------------------------------------------
interface csa_seq_mult_if #(
    parameter int WIDTH = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] result_o;
    logic               busy;
`ifdef CSA_SEQ_MULT_ACCUM_EN
    logic               acc_i;

    modport master (
        output in_valid, a_i, b_i, out_ready, acc_i,
        input  in_ready, out_valid, result_o, busy
    );

    modport slave (
        input  in_valid, a_i, b_i, out_ready, acc_i,
        output in_ready, out_valid, result_o, busy
    );
`else
    modport master (
        output in_valid, a_i, b_i, out_ready,
        input  in_ready, out_valid, result_o, busy
    );

    modport slave (
        input  in_valid, a_i, b_i, out_ready,
        output in_ready, out_valid, result_o, busy
    );
`endif
endinterface

// File: rtl/csa_3to2.sv
// -----------------------------------------------------------------------------
// csa_3to2
// Bitwise 3:2 carry-save compressor of parametrised width.
//   x, y, z : three addends
//   sum     : x ^ y ^ z
//   carry   : majority(x, y, z) shifted left one place (MSB dropped)
// sum + carry == x + y + z modulo 2^W.
// -----------------------------------------------------------------------------
module csa_3to2 #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);
    logic [W-1:0] maj;

    assign sum   = x ^ y ^ z;
    assign maj   = (x & y) | (x & z) | (y & z);
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_seq_mult.sv
// -----------------------------------------------------------------------------
// csa_seq_mult
// Sequential unsigned multiplier retiring K multiplier bits per cycle into a
// carry-save sum/carry pair, with a single carry-propagate add at the end.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : csa_seq_mult_if.slave (operand/result handshakes, busy)
//   state : current FSM state, for observation
// Latency: out_valid rises WIDTH/K + 1 edges after operand acceptance.
// Optional macro CSA_SEQ_MULT_ACCUM_EN: acc_i=1 at acceptance seeds the sum
// with the current result_o so the new result is previous + a*b.
// -----------------------------------------------------------------------------
module csa_seq_mult
    import csa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int K     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    csa_seq_mult_if.slave      bus,
    output csa_state_t         state
);
    localparam int PW    = 2 * WIDTH;
    localparam int STEPS = WIDTH / K;
    localparam int CW    = cnt_width(WIDTH, K);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    generate
        if (WIDTH < 4 || WIDTH > 64 || K < 1 || K > WIDTH || (WIDTH % K) != 0) begin : g_bad_cfg
            $error("csa_seq_mult: illegal WIDTH/K combination");
        end
    endgenerate

    csa_state_t      state_q;
    logic [PW-1:0]   a_sh;      // multiplicand, pre-shifted to the current bit position
    logic [WIDTH-1:0] b_sh;     // multiplier, low K bits are the ones retired this cycle
    logic [PW-1:0]   sum_q;
    logic [PW-1:0]   carry_q;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   result_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [PW-1:0]   seed;

    // Carry-save chain: stage j folds partial product j into the pair from
    // stage j-1. No carries propagate across bit positions here.
    logic [PW-1:0] s_chain [K+1];
    logic [PW-1:0] c_chain [K+1];
    logic [PW-1:0] pp      [K];

    assign s_chain[0] = sum_q;
    assign c_chain[0] = carry_q;

    generate
        for (genvar j = 0; j < K; j++) begin : g_stage
            assign pp[j] = b_sh[j] ? (a_sh << j) : '0;

            csa_3to2 #(.W(PW)) u_csa (
                .x     (s_chain[j]),
                .y     (c_chain[j]),
                .z     (pp[j]),
                .sum   (s_chain[j+1]),
                .carry (c_chain[j+1])
            );
        end
    endgenerate

`ifdef CSA_SEQ_MULT_ACCUM_EN
    assign seed = bus.acc_i ? result_q : '0;
`else
    assign seed = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            cnt         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_sh       <= {{WIDTH{1'b0}}, bus.a_i};
                        b_sh       <= bus.b_i;
                        sum_q      <= seed;
                        carry_q    <= '0;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q   <= s_chain[K];
                    carry_q <= c_chain[K];
                    a_sh    <= a_sh << K;
                    b_sh    <= b_sh >> K;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_q <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    result_q    <= sum_q + carry_q;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result_o  = result_q;
    assign bus.busy      = busy_q;
    assign state         = state_q;

endmodule

// File: tb/tb_csa_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_csa_seq_mult
// Directed bench for csa_seq_mult. Main DUT at WIDTH=32/K=2, plus K=1 and
// K=4 instances for the all-ones latency/result case. The reference model is
// plain 64-bit arithmetic (a*b, optionally plus the previous result) kept in
// an expected queue; literal products pin the model.
// -----------------------------------------------------------------------------
module tb_csa_seq_mult;
    import csa_pkg::*;

    logic clk;
    logic rst_n;

    csa_seq_mult_if #(.WIDTH(32)) bus_k2 ();
    csa_seq_mult_if #(.WIDTH(32)) bus_k1 ();
    csa_seq_mult_if #(.WIDTH(32)) bus_k4 ();
    csa_state_t state_k2, state_k1, state_k4;

    csa_seq_mult #(.WIDTH(32), .K(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_k2), .state(state_k2));
    csa_seq_mult #(.WIDTH(32), .K(1)) dut_k1 (.clk(clk), .rst_n(rst_n), .bus(bus_k1), .state(state_k1));
    csa_seq_mult #(.WIDTH(32), .K(4)) dut_k4 (.clk(clk), .rst_n(rst_n), .bus(bus_k4), .state(state_k4));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_last = '0;   // value result_o must hold between operations

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every cycle the result is valid it must equal the head of the model queue.
    always @(negedge clk) begin
        if (rst_n && bus_k2.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                check("result_vs_model", bus_k2.result_o, exp_q[0]);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus_k2.out_valid && bus_k2.out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic acc,
                          input int hold, input logic rdy_early,
                          input logic [63:0] lit, input logic use_lit);
        int g;
        int n;
        logic [63:0] prod;
        logic [63:0] r;
        g = 0;
        while (!bus_k2.in_ready && g < 50) begin
            @(posedge clk); #1; g++;
        end
        check("in_ready_before_op", 64'(bus_k2.in_ready), 64'd1);
        bus_k2.a_i       = a;
        bus_k2.b_i       = b;
`ifdef CSA_SEQ_MULT_ACCUM_EN
        bus_k2.acc_i     = acc;
`endif
        bus_k2.in_valid  = 1'b1;
        bus_k2.out_ready = rdy_early;
        @(posedge clk);
        prod = {32'd0, a} * {32'd0, b};
`ifdef CSA_SEQ_MULT_ACCUM_EN
        if (acc) prod = model_last + prod;
`else
        if (acc) prod = prod;
`endif
        model_last = prod;
        exp_q.push_back(prod);
        #1;
        bus_k2.in_valid = 1'b0;
        bus_k2.a_i      = $urandom;
        bus_k2.b_i      = $urandom;
        check("busy_after_accept", 64'(bus_k2.busy), 64'd1);
        check("in_ready_after_accept", 64'(bus_k2.in_ready), 64'd0);
        // Keep presenting ignored operands while the block is busy.
        n = 0;
        while (n < 100) begin
            bus_k2.in_valid = 1'b1;
            @(posedge clk); n++; #1;
            bus_k2.a_i = $urandom;
            bus_k2.b_i = $urandom;
            if (bus_k2.out_valid) break;
        end
        bus_k2.in_valid = 1'b0;
        check("latency_k2", 64'(n), 64'd17);
        if (use_lit) check("result_literal", bus_k2.result_o, lit);
        if (!rdy_early) begin
            for (int i = 0; i < hold; i++) begin
                r = bus_k2.result_o;
                bus_k2.in_valid = 1'b1;
                bus_k2.a_i = $urandom;
                bus_k2.b_i = $urandom;
                @(posedge clk); #1;
                check("hold_out_valid", 64'(bus_k2.out_valid), 64'd1);
                check("hold_result_stable", bus_k2.result_o, r);
                check("hold_in_ready_low", 64'(bus_k2.in_ready), 64'd0);
            end
            bus_k2.in_valid  = 1'b0;
            bus_k2.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus_k2.out_ready = 1'b0;
        check("out_valid_after_hs", 64'(bus_k2.out_valid), 64'd0);
        check("in_ready_after_hs", 64'(bus_k2.in_ready), 64'd1);
        check("result_kept_after_hs", bus_k2.result_o, model_last);
    endtask

    task automatic run_aux_all_ones();
        int lat1;
        int lat4;
        logic [63:0] res1;
        logic [63:0] res4;
        lat1 = -1; lat4 = -1; res1 = '0; res4 = '0;
        bus_k1.a_i = 32'hFFFF_FFFF; bus_k1.b_i = 32'hFFFF_FFFF;
        bus_k4.a_i = 32'hFFFF_FFFF; bus_k4.b_i = 32'hFFFF_FFFF;
        bus_k1.out_ready = 1'b1; bus_k4.out_ready = 1'b1;
        bus_k1.in_valid = 1'b1; bus_k4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_k1.in_valid = 1'b0; bus_k4.in_valid = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (bus_k1.out_valid && lat1 < 0) begin lat1 = n; res1 = bus_k1.result_o; end
            if (bus_k4.out_valid && lat4 < 0) begin lat4 = n; res4 = bus_k4.result_o; end
        end
        bus_k1.out_ready = 1'b0; bus_k4.out_ready = 1'b0;
        check("latency_k1", 64'(lat1), 64'd33);
        check("latency_k4", 64'(lat4), 64'd9);
        check("result_k1_ones", res1, 64'hFFFF_FFFE_0000_0001);
        check("result_k4_ones", res4, 64'hFFFF_FFFE_0000_0001);
    endtask

    task automatic reset_mid_run();
        int seen;
        bus_k2.a_i = 32'd5; bus_k2.b_i = 32'd7;
`ifdef CSA_SEQ_MULT_ACCUM_EN
        bus_k2.acc_i = 1'b0;
`endif
        bus_k2.out_ready = 1'b1;
        bus_k2.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus_k2.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        model_last = '0;
        #1;
        check("rst_out_valid", 64'(bus_k2.out_valid), 64'd0);
        check("rst_busy", 64'(bus_k2.busy), 64'd0);
        check("rst_result", bus_k2.result_o, 64'd0);
        check("rst_in_ready", 64'(bus_k2.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus_k2.out_valid) seen++;
        end
        bus_k2.out_ready = 1'b0;
        check("no_out_valid_after_rst", 64'(seen), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        bus_k2.in_valid = 1'b0; bus_k2.a_i = '0; bus_k2.b_i = '0; bus_k2.out_ready = 1'b0;
        bus_k1.in_valid = 1'b0; bus_k1.a_i = '0; bus_k1.b_i = '0; bus_k1.out_ready = 1'b0;
        bus_k4.in_valid = 1'b0; bus_k4.a_i = '0; bus_k4.b_i = '0; bus_k4.out_ready = 1'b0;
`ifdef CSA_SEQ_MULT_ACCUM_EN
        bus_k2.acc_i = 1'b0; bus_k1.acc_i = 1'b0; bus_k4.acc_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus_k2.out_valid), 64'd0);
        check("reset_busy", 64'(bus_k2.busy), 64'd0);
        check("reset_result", bus_k2.result_o, 64'd0);
        check("reset_in_ready", 64'(bus_k2.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd0, 32'd0, 1'b0, 0, 1'b0, 64'd0, 1'b1);
        run_op(32'd100000, 32'd100000000, 1'b0, 0, 1'b0, 64'h0000_0918_4E72_A000, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b1, 64'hFFFF_FFFE_0000_0001, 1'b1);
        run_op(32'h0000_1234, 32'h0000_5678, 1'b0, 5, 1'b0, 64'h0000_0000_0626_0060, 1'b1);
        run_op(32'h8000_0000, 32'd2, 1'b0, 1, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 2, 1'b1, 64'd0, 1'b0);
        run_op(32'd1, 32'hFFFF_FFFF, 1'b0, 0, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1);

        reset_mid_run();
        run_op(32'd12, 32'd71, 1'b0, 0, 1'b0, 64'd852, 1'b1);

`ifdef CSA_SEQ_MULT_ACCUM_EN
        run_op(32'd2, 32'd3, 1'b0, 0, 1'b0, 64'd6, 1'b1);
        run_op(32'd4, 32'd5, 1'b1, 0, 1'b0, 64'd26, 1'b1);
`endif

        run_aux_all_ones();

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
